// File: rtl/hbram_memtest_pkg.sv
// Shared types and constants for the hyperRAM AXI memory tester.
// The pattern source is selected by the HBRAM_MEMTEST_LFSR_EN macro (see hbram_memtest_pattern).
package hbram_memtest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WA,
      ST_WD,
      ST_WB,
      ST_RA,
      ST_RD,
      ST_DONE
   } state_t;

   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/hbram_memtest_pattern.sv
// Test pattern generator, one instance per phase.
// HBRAM_MEMTEST_LFSR_EN selects a seeded LFSR; otherwise the beat byte address is the pattern.
module hbram_memtest_pattern #(
   parameter int          AXI_DBW = 32,
   parameter logic [31:0] SEED    = 32'hACE1_0001
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic               i_step,
   input  logic [31:0]        i_beat_addr,
   output logic [AXI_DBW-1:0] o_pattern
);
   import hbram_memtest_pkg::*;

   logic w_unused;

`ifdef HBRAM_MEMTEST_LFSR_EN
   logic [31:0] r_lfsr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_lfsr <= SEED;
      else if (i_load) r_lfsr <= SEED;
      else if (i_step) r_lfsr <= lfsr_next(r_lfsr);
   end

   assign w_unused  = ^i_beat_addr;
   assign o_pattern = {(AXI_DBW/32){r_lfsr}};
`else
   assign w_unused  = ^{i_clk, i_rst_n, i_load, i_step, SEED};
   assign o_pattern = {(AXI_DBW/32){i_beat_addr}};
`endif

endmodule

// File: rtl/hbram_axi_memtest.sv
// Built-in AXI write/read-back memory test for the hyperRAM controller (one transaction in flight).
// Optional macro HBRAM_MEMTEST_LFSR_EN switches the data pattern to an LFSR sequence.
module hbram_axi_memtest #(
   parameter int          AXI_DBW    = 32,
   parameter logic [31:0] START_ADDR = 32'h0,
   parameter int          BURST_LEN  = 16,
   parameter int          NUM_BURSTS = 64,
   parameter logic [7:0]  AXI_ID     = 8'h5A,
   parameter logic [31:0] SEED       = 32'hACE1_0001
) (
   input  logic                   io_axi_clk,
   input  logic                   io_axi_rstn,
   input  logic                   start,
   output logic                   io_arw_valid,
   input  logic                   io_arw_ready,
   output logic [31:0]            io_arw_payload_addr,
   output logic [7:0]             io_arw_payload_id,
   output logic [7:0]             io_arw_payload_len,
   output logic [2:0]             io_arw_payload_size,
   output logic [1:0]             io_arw_payload_burst,
   output logic [1:0]             io_arw_payload_lock,
   output logic                   io_arw_payload_write,
   output logic                   io_w_valid,
   input  logic                   io_w_ready,
   output logic [7:0]             io_w_payload_id,
   output logic [AXI_DBW-1:0]     io_w_payload_data,
   output logic [AXI_DBW/8-1:0]   io_w_payload_strb,
   output logic                   io_w_payload_last,
   input  logic                   io_b_valid,
   output logic                   io_b_ready,
   input  logic [7:0]             io_b_payload_id,
   input  logic                   io_r_valid,
   output logic                   io_r_ready,
   input  logic [AXI_DBW-1:0]     io_r_payload_data,
   input  logic [7:0]             io_r_payload_id,
   input  logic [1:0]             io_r_payload_resp,
   input  logic                   io_r_payload_last,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [15:0]            err_cnt,
   output logic [31:0]            first_err_addr
);
   import hbram_memtest_pkg::*;

   localparam int          AXSIZE      = $clog2(AXI_DBW/8);
   localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * (AXI_DBW/8));
   localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
   localparam logic [31:0] LAST_BURST  = 32'(NUM_BURSTS - 1);

   state_t              r_state, w_state_nxt;
   logic [31:0]         r_addr, r_burst, r_first_err_addr;
   logic [7:0]          r_beat;
   logic [15:0]         r_err_cnt;
   logic                r_err_seen;

   logic                w_clear, w_rd_load;
   logic                w_beat_last, w_last_burst, w_beat_err, w_rd_end;
   logic [31:0]         w_beat_addr;
   logic [AXI_DBW-1:0]  w_wr_pat, w_rd_pat;

   assign w_beat_addr  = r_addr + (32'(r_beat) << AXSIZE);
   assign w_beat_last  = (r_beat == LAST_BEAT);
   assign w_last_burst = (r_burst == LAST_BURST);
   assign w_rd_end     = io_r_payload_last | w_beat_last;
   assign w_beat_err   = (io_r_payload_data != w_rd_pat) | (io_r_payload_resp != AXI_RESP_OKAY) |
                         (io_r_payload_id != AXI_ID) | (io_r_payload_last != w_beat_last);

   hbram_memtest_pattern #(.AXI_DBW(AXI_DBW), .SEED(SEED)) u_wr_pat (
      .i_clk(io_axi_clk), .i_rst_n(io_axi_rstn), .i_load(w_clear),
      .i_step((r_state == ST_WD) && io_w_ready), .i_beat_addr(w_beat_addr), .o_pattern(w_wr_pat)
   );

   hbram_memtest_pattern #(.AXI_DBW(AXI_DBW), .SEED(SEED)) u_rd_pat (
      .i_clk(io_axi_clk), .i_rst_n(io_axi_rstn), .i_load(w_rd_load),
      .i_step((r_state == ST_RD) && io_r_valid), .i_beat_addr(w_beat_addr), .o_pattern(w_rd_pat)
   );

   always_ff @(posedge io_axi_clk or negedge io_axi_rstn) begin
      if (!io_axi_rstn) r_state <= ST_IDLE;
      else              r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt          = r_state;
      io_arw_valid         = 1'b0;
      io_arw_payload_write = 1'b0;
      io_w_valid           = 1'b0;
      io_b_ready           = 1'b0;
      io_r_ready           = 1'b0;
      busy                 = 1'b1;
      done                 = 1'b0;
      pass                 = 1'b0;
      w_clear              = 1'b0;
      w_rd_load            = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_WA;
            end
         end
         ST_WA: begin
            io_arw_valid         = 1'b1;
            io_arw_payload_write = 1'b1;
            if (io_arw_ready) w_state_nxt = ST_WD;
         end
         ST_WD: begin
            io_w_valid = 1'b1;
            if (io_w_ready && w_beat_last) w_state_nxt = ST_WB;
         end
         ST_WB: begin
            io_b_ready = 1'b1;
            if (io_b_valid) begin
               w_rd_load   = w_last_burst;
               w_state_nxt = w_last_burst ? ST_RA : ST_WA;
            end
         end
         ST_RA: begin
            io_arw_valid = 1'b1;
            if (io_arw_ready) w_state_nxt = ST_RD;
         end
         ST_RD: begin
            io_r_ready = 1'b1;
            if (io_r_valid && w_rd_end) w_state_nxt = w_last_burst ? ST_DONE : ST_RA;
         end
         ST_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            pass = (r_err_cnt == 16'd0);
            if (start) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Burst/beat bookkeeping; the last burst of a phase rewinds to START_ADDR for the next phase
   always_ff @(posedge io_axi_clk or negedge io_axi_rstn) begin
      if (!io_axi_rstn) begin
         r_addr           <= START_ADDR;
         r_burst          <= '0;
         r_beat           <= '0;
         r_err_cnt        <= '0;
         r_err_seen       <= 1'b0;
         r_first_err_addr <= '0;
      end else if (w_clear) begin
         r_addr           <= START_ADDR;
         r_burst          <= '0;
         r_beat           <= '0;
         r_err_cnt        <= '0;
         r_err_seen       <= 1'b0;
         r_first_err_addr <= '0;
      end else begin
         case (r_state)
            ST_WD: if (io_w_ready) r_beat <= w_beat_last ? '0 : r_beat + 8'd1;
            ST_WB: if (io_b_valid) begin
               if (io_b_payload_id != AXI_ID) r_err_cnt <= sat_inc(r_err_cnt);
               r_burst <= w_last_burst ? '0 : r_burst + 32'd1;
               r_addr  <= w_last_burst ? START_ADDR : r_addr + BURST_BYTES;
            end
            ST_RD: if (io_r_valid) begin
               if (w_beat_err) begin
                  r_err_cnt <= sat_inc(r_err_cnt);
                  if (!r_err_seen) begin
                     r_err_seen       <= 1'b1;
                     r_first_err_addr <= w_beat_addr;
                  end
               end
               if (w_rd_end) begin
                  r_beat  <= '0;
                  r_burst <= w_last_burst ? '0 : r_burst + 32'd1;
                  r_addr  <= w_last_burst ? START_ADDR : r_addr + BURST_BYTES;
               end else begin
                  r_beat <= r_beat + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_arw_payload_addr  = r_addr;
   assign io_arw_payload_id    = AXI_ID;
   assign io_arw_payload_len   = LAST_BEAT;
   assign io_arw_payload_size  = 3'(AXSIZE);
   assign io_arw_payload_burst = AXI_BURST_INCR;
   assign io_arw_payload_lock  = 2'b00;
   assign io_w_payload_id      = AXI_ID;
   assign io_w_payload_data    = w_wr_pat;
   assign io_w_payload_strb    = '1;
   assign io_w_payload_last    = (r_state == ST_WD) && w_beat_last;
   assign err_cnt              = r_err_cnt;
   assign first_err_addr       = r_first_err_addr;

endmodule

// File: tb/tb_hbram_axi_memtest.sv
// Bench for hbram_axi_memtest: behavioural AXI slave memory plus a queue-based scoreboard.
// Honours HBRAM_MEMTEST_LFSR_EN when computing the expected write pattern.
module tb_hbram_axi_memtest;

   localparam int          DBW  = 32;
   localparam int          BL   = 4;
   localparam int          NB   = 2;
   localparam logic [7:0]  ID   = 8'h5A;
   localparam logic [31:0] SEED = 32'hACE1_0001;

   logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
   logic        arw_valid, arw_ready, arw_write;
   logic [31:0] arw_addr;
   logic [7:0]  arw_id, arw_len;
   logic [2:0]  arw_size;
   logic [1:0]  arw_burst, arw_lock;
   logic        w_valid, w_ready, w_last;
   logic [7:0]  w_id;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        b_valid, b_ready;
   logic        r_valid, r_ready, r_last;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        busy, done, pass;
   logic [15:0] err_cnt;
   logic [31:0] first_err_addr;

   always #5 clk = ~clk;

   hbram_axi_memtest #(
      .AXI_DBW(DBW), .START_ADDR(32'h0), .BURST_LEN(BL), .NUM_BURSTS(NB), .AXI_ID(ID), .SEED(SEED)
   ) dut (
      .io_axi_clk(clk), .io_axi_rstn(rstn), .start(start),
      .io_arw_valid(arw_valid), .io_arw_ready(arw_ready), .io_arw_payload_addr(arw_addr),
      .io_arw_payload_id(arw_id), .io_arw_payload_len(arw_len), .io_arw_payload_size(arw_size),
      .io_arw_payload_burst(arw_burst), .io_arw_payload_lock(arw_lock),
      .io_arw_payload_write(arw_write),
      .io_w_valid(w_valid), .io_w_ready(w_ready), .io_w_payload_id(w_id),
      .io_w_payload_data(w_data), .io_w_payload_strb(w_strb), .io_w_payload_last(w_last),
      .io_b_valid(b_valid), .io_b_ready(b_ready), .io_b_payload_id(ID),
      .io_r_valid(r_valid), .io_r_ready(r_ready), .io_r_payload_data(r_data),
      .io_r_payload_id(ID), .io_r_payload_resp(r_resp), .io_r_payload_last(r_last),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
   );

   int n_tests = 0, n_fail = 0;
   logic [32:0] arw_q[$];   // {write, addr}
   logic [32:0] w_q[$];     // {last, data}
   logic [48:0] st_q[$];    // {pass, err_cnt, first_err_addr}
   logic [31:0] mem[logic [31:0]];

   logic        bp = 1'b0, flip_en = 1'b0, resp_en = 1'b0, early_en = 1'b0;
   logic [31:0] flip_addr = '0, resp_addr = '0, early_addr = '0;
   int          early_beat = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   // Slave memory: decides ready/valid just after each rising edge; the handshake lands on the next edge
   initial begin
      int phase, beat;
      logic [31:0] baddr, a;
      phase = 0; beat = 0; baddr = '0;
      arw_ready = 0; w_ready = 0; b_valid = 0; r_valid = 0; r_last = 0; r_data = '0; r_resp = '0;
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            arw_ready = 0; w_ready = 0; b_valid = 0; r_valid = 0; r_last = 0;
            phase = 0; beat = 0;
         end else begin
            #1;
            arw_ready = 0; w_ready = 0; b_valid = 0; r_valid = 0; r_last = 0;
            r_data = '0; r_resp = '0;
            case (phase)
               0: begin
                  arw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                  if (arw_valid && arw_ready) begin
                     baddr = arw_addr; beat = 0;
                     phase = arw_write ? 1 : 3;
                  end
               end
               1: begin
                  w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                  if (w_valid && w_ready) begin
                     mem[baddr + 32'(4 * beat)] = w_data;
                     beat++;
                     if (w_last) phase = 2;
                  end
               end
               2: begin
                  b_valid = 1'b1;
                  if (b_ready) phase = 0;
               end
               default: begin
                  r_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                  if (r_valid) begin
                     a = baddr + 32'(4 * beat);
                     r_data = mem.exists(a) ? mem[a] : '0;
                     if (flip_en && a == flip_addr) r_data[0] = ~r_data[0];
                     if (resp_en && baddr == resp_addr) r_resp = 2'b10;
                     r_last = (beat == BL - 1) || (early_en && baddr == early_addr && beat == early_beat);
                     if (r_ready) begin
                        beat++;
                        if (r_last) phase = 0;
                     end
                  end
               end
            endcase
         end
      end
   end

   // Monitor: compares presented payloads against queue heads, pops on handshake
   initial begin
      logic prev_done;
      logic [32:0] e;
      logic [48:0] s;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_done = 1'b0;
         end else begin
            if (arw_valid) begin
               if (arw_q.size() == 0) chk("arw_unexpected", 1, 0);
               else begin
                  e = arw_q[0];
                  chk("arw_addr", arw_addr, e[31:0]);
                  chk("arw_write", arw_write, e[32]);
                  if (arw_ready) begin
                     chk("arw_ctl", {arw_id, arw_len, arw_size, arw_burst, arw_lock},
                         {ID, 8'(BL - 1), 3'd2, 2'b01, 2'b00});
                     void'(arw_q.pop_front());
                  end
               end
            end
            if (w_valid) begin
               if (w_q.size() == 0) chk("w_unexpected", 1, 0);
               else begin
                  e = w_q[0];
                  chk("w_data", w_data, e[31:0]);
                  chk("w_last", w_last, e[32]);
                  if (w_ready) begin
                     chk("w_id_strb", {w_id, w_strb}, {ID, 4'hF});
                     void'(w_q.pop_front());
                  end
               end
            end
            if (done && !prev_done) begin
               if (st_q.size() == 0) chk("status_unexpected", 1, 0);
               else begin
                  s = st_q.pop_front();
                  chk("pass", pass, s[48]);
                  chk("err_cnt", err_cnt, s[47:32]);
                  chk("first_err_addr", first_err_addr, s[31:0]);
                  chk("busy_in_done", busy, 0);
               end
            end
            prev_done = done;
         end
      end
   end

   task automatic push_run(input logic p, input logic [15:0] e, input logic [31:0] fa);
      logic [31:0] pat;
      pat = SEED;
      for (int b = 0; b < NB; b++) arw_q.push_back({1'b1, 32'(b * BL * 4)});
      for (int k = 0; k < NB * BL; k++) begin
`ifdef HBRAM_MEMTEST_LFSR_EN
         w_q.push_back({1'((k % BL) == BL - 1), pat});
         pat = lfsr_nx(pat);
`else
         w_q.push_back({1'((k % BL) == BL - 1), 32'(k * 4)});
`endif
      end
      for (int b = 0; b < NB; b++) arw_q.push_back({1'b0, 32'(b * BL * 4)});
      st_q.push_back({p, e, fa});
   endtask

   task automatic launch();
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
      chk("busy_after_start", busy, 1);
      start = 1'b0;
   endtask

   task automatic run_test(input logic p, input logic [15:0] e, input logic [31:0] fa);
      push_run(p, e, fa);
      launch();
      for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
      chk("done_timeout", done, 1);
      repeat (2) @(negedge clk);
      chk("arw_q_left", arw_q.size(), 0);
      chk("w_q_left", w_q.size(), 0);
      chk("st_q_left", st_q.size(), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valids", {arw_valid, w_valid, b_ready, r_ready}, 4'b0000);
      chk("rst_status", {busy, done, pass}, 3'b000);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_first_err", first_err_addr, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outputs();

      run_test(1'b1, 16'd0, 32'h0);

      flip_en = 1'b1; flip_addr = 32'h14;
      run_test(1'b0, 16'd1, 32'h14);
      flip_en = 1'b0;

      bp = 1'b1;
      run_test(1'b1, 16'd0, 32'h0);
      bp = 1'b0;

      resp_en = 1'b1; resp_addr = 32'h10;
      run_test(1'b0, 16'd4, 32'h10);
      resp_en = 1'b0;

      early_en = 1'b1; early_addr = 32'h10; early_beat = 2;
      run_test(1'b0, 16'd1, 32'h18);
      early_en = 1'b0;

      push_run(1'b1, 16'd0, 32'h0);
      launch();
      for (int i = 0; i < 50 && !w_valid; i++) @(negedge clk);
      chk("reach_wd", w_valid, 1);
      #2 rstn = 1'b0;
      #1 chk_reset_outputs();
      @(posedge clk); #1;
      chk_reset_outputs();
      arw_q.delete(); w_q.delete(); st_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk_reset_outputs();

      run_test(1'b1, 16'd0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
